multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-style sequencing controller: fetch/decode/exec/mem/writeback
// FSM with bounded memory waits and a sticky trap state.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r_type,
  input  logic       i_type,
  input  logic       store,
  input  logic       load,
  input  logic       branch,
  input  logic       jalr,
  input  logic       jal,
  input  logic       auipc,
  input  logic       lui,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       trap,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam int C_R     = 8;
  localparam int C_I     = 7;
  localparam int C_ST    = 6;
  localparam int C_LD    = 5;
  localparam int C_BR    = 4;
  localparam int C_JALR  = 3;
  localparam int C_JAL   = 2;
  localparam int C_AUIPC = 1;
  localparam int C_LUI   = 0;

  // Counter value on the last allowed wait cycle; a low ready here times out.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     cur;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic [8:0] cls;
  logic       trap_q;
  logic [8:0] flags;
  logic       one_hot;
  logic       waiting;
  logic       timeout;

  assign flags   = {r_type, i_type, store, load, branch, jalr, jal, auipc, lui};
  assign one_hot = (flags != '0) && ((flags & (flags - 9'd1)) == '0);
  assign waiting = ((cur == FETCH) && !imem_ready) || ((cur == MEM) && !dmem_ready);
  assign timeout = waiting && (wait_cnt == TO_LAST);

  assign state = cur;
  assign trap  = trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= FETCH;
      wait_cnt <= '0;
      cls      <= '0;
      trap_q   <= 1'b0;
    end else begin
      cur <= nxt;
      // Any cycle that is not a wait cycle clears the counter, so every
      // entry to FETCH or MEM starts counting from zero.
      if (waiting && !timeout) wait_cnt <= wait_cnt + 8'd1;
      else                     wait_cnt <= '0;
      if (cur == DECODE) cls <= flags;
      if (nxt == TRAP) trap_q <= 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH: begin
        if (imem_ready)   nxt = DECODE;
        else if (timeout) nxt = TRAP;
      end
      DECODE: nxt = one_hot ? EXEC : TRAP;
      EXEC: begin
        if (cls[C_LD] || cls[C_ST]) nxt = MEM;
        else if (cls[C_BR])         nxt = FETCH;
        else                        nxt = WB;
      end
      MEM: begin
        if (dmem_ready)   nxt = cls[C_LD] ? WB : FETCH;
        else if (timeout) nxt = TRAP;
      end
      WB:      nxt = FETCH;
      TRAP:    nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    wb_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    // Outputs are forced quiet during reset so an in-flight instruction
    // never commits a register or PC write.
    if (!rst) begin
      case (cur)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        EXEC: begin
          if (cls[C_BR]) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? 2'd1 : 2'd0;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls[C_ST];
          if (dmem_ready && cls[C_ST]) pc_we = 1'b1;
        end
        WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
          if (cls[C_JAL])       pc_sel = 2'd1;
          else if (cls[C_JALR]) pc_sel = 2'd2;
        end
        default: ;
      endcase
      if (cur inside {EXEC, MEM, WB}) begin
        alu_a_sel = cls[C_AUIPC] | cls[C_JAL];
        alu_b_sel = cls[C_I] | cls[C_LD] | cls[C_ST] | cls[C_JALR] | cls[C_AUIPC] | cls[C_JAL];
        if (cls[C_LD])                    wb_sel = 2'd1;
        else if (cls[C_JAL] || cls[C_JALR]) wb_sel = 2'd2;
        else if (cls[C_LUI])              wb_sel = 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors for
// each instruction class, wait/timeout boundaries, decode faults and reset aborts.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] flags;
  logic       branch_taken, imem_ready, dmem_ready;
  logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
  logic [1:0] pc_sel, wb_sel;
  logic       alu_a_sel, alu_b_sel, trap;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  localparam logic [8:0] F_R = 9'h100, F_I = 9'h080, F_ST = 9'h040, F_LD = 9'h020;
  localparam logic [8:0] F_BR = 9'h010, F_JALR = 9'h008, F_JAL = 9'h004;
  localparam logic [8:0] F_AUIPC = 9'h002, F_LUI = 9'h001;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .r_type(flags[8]), .i_type(flags[7]), .store(flags[6]), .load(flags[5]),
    .branch(flags[4]), .jalr(flags[3]), .jal(flags[2]), .auipc(flags[1]), .lui(flags[0]),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .trap(trap), .state(state)
  );

  // Stimulus word: {rst, imem_ready, dmem_ready, branch_taken, flags}
  function automatic logic [12:0] s(input logic r, ir, dr, bt, input logic [8:0] f);
    return {r, ir, dr, bt, f};
  endfunction

  // Output word: {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, wb_sel, a, b, trap}
  function automatic logic [15:0] e(input logic [2:0] st, input logic ireq, irwe, dreq, dwe,
                                    rfwe, pcwe, input logic [1:0] ps, ws, input logic aa, ab, tr);
    return {st, ireq, irwe, dreq, dwe, rfwe, pcwe, ps, ws, aa, ab, tr};
  endfunction

  function automatic logic [15:0] snap();
    return {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, wb_sel,
            alu_a_sel, alu_b_sel, trap};
  endfunction

  task automatic drive(input logic [12:0] v);
    {rst, imem_ready, dmem_ready, branch_taken, flags} = v;
  endtask

  task automatic test_reset();
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(1,1,1,1,F_R);   ev[0] = e(0,0,0,0,0,0,0,0,0,0,0,0);
    st[1] = s(1,1,0,0,F_LD);  ev[1] = e(0,0,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,0,0,0,0);     ev[2] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r_type();
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(0,1,0,0,0);     ev[0] = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[1] = s(0,0,0,0,F_R);   ev[1] = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,0,0,0,F_LD);  ev[2] = e(2,0,0,0,0,0,0,0,0,0,0,0);
    st[3] = s(0,0,0,0,0);     ev[3] = e(4,0,0,0,0,1,1,0,0,0,0,0);
    st[4] = s(0,0,0,0,0);     ev[4] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL r_type cyc%0d got=%h exp=%h", i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(0,1,0,0,0);     ev[0] = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[1] = s(0,0,0,0,F_LD);  ev[1] = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,0,0,0,0);     ev[2] = e(2,0,0,0,0,0,0,0,1,0,1,0);
    st[3] = s(0,0,0,0,0);     ev[3] = e(3,0,0,1,0,0,0,0,1,0,1,0);
    st[4] = s(0,0,0,0,0);     ev[4] = e(3,0,0,1,0,0,0,0,1,0,1,0);
    st[5] = s(0,0,0,0,0);     ev[5] = e(3,0,0,1,0,0,0,0,1,0,1,0);
    // Ready arrives on the cycle the wait count hits the limit: no trap.
    st[6] = s(0,0,1,0,0);     ev[6] = e(3,0,0,1,0,0,0,0,1,0,1,0);
    st[7] = s(0,1,0,0,0);     ev[7] = e(4,0,0,0,0,1,1,0,1,0,1,0);
    st[8] = s(0,0,0,0,0);     ev[8] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 9; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL load cyc%0d got=%h exp=%h", i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(0,1,0,0,0);     ev[0] = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[1] = s(0,0,0,0,F_ST);  ev[1] = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,0,0,0,0);     ev[2] = e(2,0,0,0,0,0,0,0,0,0,1,0);
    st[3] = s(0,0,0,0,0);     ev[3] = e(3,0,0,1,1,0,0,0,0,0,1,0);
    st[4] = s(0,0,1,0,0);     ev[4] = e(3,0,0,1,1,0,1,0,0,0,1,0);
    st[5] = s(0,0,0,0,0);     ev[5] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL store cyc%0d got=%h exp=%h", i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch(input logic bt);
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(0,1,0,0,0);     ev[0] = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[1] = s(0,0,0,0,F_BR);  ev[1] = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,0,0,bt,0);    ev[2] = e(2,0,0,0,0,0,1,{1'b0, bt},0,0,0,0);
    st[3] = s(0,0,0,0,0);     ev[3] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL branch_bt%0d cyc%0d got=%h exp=%h", bt, i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wb_class(input string name, input logic [8:0] f, input logic aa, ab,
                               input logic [1:0] ws, ps);
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(0,1,0,0,0);     ev[0] = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[1] = s(0,0,0,0,f);     ev[1] = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,0,0,0,0);     ev[2] = e(2,0,0,0,0,0,0,0,ws,aa,ab,0);
    st[3] = s(0,0,0,0,0);     ev[3] = e(4,0,0,0,0,1,1,ps,ws,aa,ab,0);
    st[4] = s(0,0,0,0,0);     ev[4] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL %s cyc%0d got=%h exp=%h", name, i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bad_decode(input string name, input logic [8:0] f);
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(0,1,0,0,0);     ev[0] = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[1] = s(0,0,0,0,f);     ev[1] = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,1,1,1,F_R);   ev[2] = e(5,0,0,0,0,0,0,0,0,0,0,1);
    st[3] = s(0,0,0,0,0);     ev[3] = e(5,0,0,0,0,0,0,0,0,0,0,1);
    st[4] = s(1,0,0,0,0);     ev[4] = e(5,0,0,0,0,0,0,0,0,0,0,1);
    st[5] = s(0,0,0,0,0);     ev[5] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL %s cyc%0d got=%h exp=%h", name, i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0] = s(1,0,0,0,0);     ev[0] = e(0,0,0,0,0,0,0,0,0,0,0,0);
    st[1] = s(0,0,0,0,0);     ev[1] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    st[2] = s(0,0,0,0,0);     ev[2] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    st[3] = s(0,0,0,0,0);     ev[3] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    st[4] = s(0,0,0,0,0);     ev[4] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    st[5] = s(0,0,0,0,0);     ev[5] = e(5,0,0,0,0,0,0,0,0,0,0,1);
    st[6] = s(0,1,1,0,F_R);   ev[6] = e(5,0,0,0,0,0,0,0,0,0,0,1);
    st[7] = s(1,1,0,0,0);     ev[7] = e(5,0,0,0,0,0,0,0,0,0,0,1);
    st[8] = s(0,0,0,0,0);     ev[8] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 9; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL timeout cyc%0d got=%h exp=%h", i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    logic [12:0] st[12];
    logic [15:0] ev[12];
    st[0]  = s(0,1,0,0,0);    ev[0]  = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[1]  = s(0,0,0,0,F_LD); ev[1]  = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[2]  = s(0,0,0,0,0);    ev[2]  = e(2,0,0,0,0,0,0,0,1,0,1,0);
    st[3]  = s(0,0,0,0,0);    ev[3]  = e(3,0,0,1,0,0,0,0,1,0,1,0);
    st[4]  = s(1,0,1,0,0);    ev[4]  = e(3,0,0,0,0,0,0,0,0,0,0,0);
    st[5]  = s(0,0,0,0,0);    ev[5]  = e(0,1,0,0,0,0,0,0,0,0,0,0);
    st[6]  = s(0,1,0,0,0);    ev[6]  = e(0,1,1,0,0,0,0,0,0,0,0,0);
    st[7]  = s(0,0,0,0,F_R);  ev[7]  = e(1,0,0,0,0,0,0,0,0,0,0,0);
    st[8]  = s(0,0,0,0,0);    ev[8]  = e(2,0,0,0,0,0,0,0,0,0,0,0);
    st[9]  = s(1,0,0,0,0);    ev[9]  = e(4,0,0,0,0,0,0,0,0,0,0,0);
    st[10] = s(0,0,0,0,0);    ev[10] = e(0,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 11; i++) begin
      drive(st[i]); #1;
      checks++;
      if (snap() !== ev[i]) begin
        failures++;
        $display("FAIL reset_abort cyc%0d got=%h exp=%h", i, snap(), ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(s(1,0,0,0,0));
    @(posedge clk); #1;
    test_reset();
    test_r_type();
    test_load();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_wb_class("jalr",   F_JALR,  1'b0, 1'b1, 2'd2, 2'd2);
    test_wb_class("jal",    F_JAL,   1'b1, 1'b1, 2'd2, 2'd1);
    test_wb_class("lui",    F_LUI,   1'b0, 1'b0, 2'd3, 2'd0);
    test_wb_class("auipc",  F_AUIPC, 1'b1, 1'b1, 2'd0, 2'd0);
    test_wb_class("i_type", F_I,     1'b0, 1'b1, 2'd0, 2'd0);
    test_bad_decode("zero_flags", 9'h000);
    test_bad_decode("multi_flags", F_R | F_LD);
    test_timeout();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
